hazard_unit: RTL

Pipeline control for the five-stage RISC-V core, and the counterpart of the execute stage. It takes the register indices, load flag and branch decision that the execute stage exports, plus MEM/WB write-back tags and the data-memory ready handshake. From these it drives the execute stage's two forwarding selects and the per-stage stall and flush controls. It also runs a memory-wait FSM with timeout detection and saturating hazard performance counters.

---
 rtl/hazard_unit_pkg.sv | 32 +++
 rtl/hazard_unit_if.sv | 49 ++++
 rtl/hazard_perf_counter.sv | 18 +
 rtl/hazard_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [1:0]       fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // Operand bypass select: the younger MEM result beats the older WB result; x0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(input reg_idx_t rs,
                                       input reg_idx_t rd_m,
                                       input logic     we_m,
                                       input reg_idx_t rd_w,
                                       input logic     we_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if ((rs != '0) && we_m && (rs == rd_m))      sel = FWD_MEM;
    else if ((rs != '0) && we_w && (rs == rd_w)) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit bundle: stage tags in, forwarding/stall/flush controls and status out.
interface hazard_unit_if #(parameter int unsigned CNT_W = 32);
  import hazard_unit_pkg::*;

  reg_idx_t         rs1_d;
  reg_idx_t         rs2_d;
  reg_idx_t         rs1_e;
  reg_idx_t         rs2_e;
  reg_idx_t         rd_e;
  logic             result_src_e_lsb;
  logic             pc_src_e;
  reg_idx_t         rd_m;
  logic             reg_write_m;
  reg_idx_t         rd_w;
  logic             reg_write_w;
  logic             mem_req_m;
  logic             mem_ready_m;
  logic             clr_cnt;

  fwd_sel_t         sel_fwd_a_e;
  fwd_sel_t         sel_fwd_b_e;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_w;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies stage tags, consumes controls.
  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_lsb, pc_src_e,
           rd_m, reg_write_m, rd_w, reg_write_w, mem_req_m, mem_ready_m, clr_cnt,
    input  sel_fwd_a_e, sel_fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_lsb, pc_src_e,
           rd_m, reg_write_m, rd_w, reg_write_w, mem_req_m, mem_ready_m, clr_cnt,
    output sel_fwd_a_e, sel_fwd_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
module hazard_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count <= '0;
    else if (clr)                    count <= '0;
    else if (inc && (count != '1))   count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard control: operand forwarding, load-use and memory-wait stalls,
// branch flushes, data-memory timeout detection and hazard performance counters.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave bus
);
  import hazard_unit_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_err_q;

  logic              load_use;
  logic              freeze;
  logic              mem_stuck;
  logic              stall_f_c;
  logic              stall_d_c;
  logic              stall_e_c;
  logic              stall_m_c;
  logic              flush_d_c;
  logic              flush_e_c;
  logic              flush_w_c;
  logic              redirect_taken;
  fwd_sel_t          sel_a_c;
  fwd_sel_t          sel_b_c;

  assign mem_stuck = bus.mem_req_m & ~bus.mem_ready_m;

  // Memory-wait FSM state register; mem_err mirrors entry into ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_err_q <= (state_next == ERR);
    end
  end

  // Next state: wait_cnt holds the number of not-ready cycles already elapsed.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stuck) begin
          state_next    = WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (bus.mem_ready_m) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next    = ERR;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  assign load_use = bus.result_src_e_lsb && (bus.rd_e != '0) &&
                    ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));
  assign freeze   = (state == ERR) || mem_stuck;

  // Stall/flush controls; freeze holds everything and defers any redirect.
  always_comb begin
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    stall_e_c = 1'b0;
    stall_m_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    flush_w_c = 1'b0;
    if (!rst_n) begin
      flush_d_c = 1'b1;
      flush_e_c = 1'b1;
      flush_w_c = 1'b1;
    end else if (freeze) begin
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      stall_e_c = 1'b1;
      stall_m_c = 1'b1;
      flush_w_c = 1'b1;
    end else begin
      flush_d_c = bus.pc_src_e;
      flush_e_c = bus.pc_src_e | load_use;
      stall_f_c = load_use & ~bus.pc_src_e;
      stall_d_c = load_use & ~bus.pc_src_e;
    end
  end

  always_comb begin
    sel_a_c = FWD_RF;
    sel_b_c = FWD_RF;
    if (rst_n) begin
      sel_a_c = fwd_sel(bus.rs1_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);
      sel_b_c = fwd_sel(bus.rs2_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);
    end
  end

  assign redirect_taken = bus.pc_src_e & ~freeze;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr_cnt),
    .inc   (stall_f_c),
    .count (bus.stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr_cnt),
    .inc   (redirect_taken),
    .count (bus.flush_cnt)
  );

  assign bus.sel_fwd_a_e = sel_a_c;
  assign bus.sel_fwd_b_e = sel_b_c;
  assign bus.stall_f     = stall_f_c;
  assign bus.stall_d     = stall_d_c;
  assign bus.stall_e     = stall_e_c;
  assign bus.stall_m     = stall_m_c;
  assign bus.flush_d     = flush_d_c;
  assign bus.flush_e     = flush_e_c;
  assign bus.flush_w     = flush_w_c;
  assign bus.mem_err     = mem_err_q;

endmodule
